// File: rtl/tree_descent_sampler.sv
// tree_descent_sampler: heap-ordered sum tree over per-topic weights.
// On start it rebuilds all internal sums bottom-up, one node per cycle.
// It then scales a random fraction by the root sum and walks from the root
// to a leaf, one level per cycle, to select a topic.
// Optional build macro TREE_DBG_RD_EN adds a combinational debug read port
// (i_dbg_addr / o_dbg_p) onto any tree node.
module tree_descent_sampler #(
    parameter int NUM_TOPICS  = 16,
    parameter int LOG2_TOPICS = 4,
    parameter int P_W         = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_wr_en,
    input  logic [LOG2_TOPICS-1:0] i_wr_addr,
    input  logic [P_W-1:0]         i_wr_p,
    input  logic                   i_start,
    input  logic [31:0]            i_random,
`ifdef TREE_DBG_RD_EN
    input  logic [LOG2_TOPICS:0]   i_dbg_addr,
    output logic [P_W-1:0]         o_dbg_p,
`endif
    output logic                   o_busy,
    output logic                   o_valid,
    output logic [31:0]            o_topic,
    output logic [P_W-1:0]         o_p_total,
    output logic                   o_zero
);

    localparam int LVL_W = (LOG2_TOPICS > 1) ? $clog2(LOG2_TOPICS) : 1;
    localparam logic [LVL_W-1:0]       LVL_LAST    = LVL_W'(LOG2_TOPICS - 1);
    localparam logic [LOG2_TOPICS-1:0] BUILD_FIRST = LOG2_TOPICS'(NUM_TOPICS - 1);
    localparam logic [LOG2_TOPICS-1:0] BUILD_LAST  = LOG2_TOPICS'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUILD,
        ST_MULT,
        ST_DESCEND,
        ST_DONE
    } state_t;

    state_t                 state_q;
    // Index 0 is never written; it only exists so node k maps to tree_q[k].
    logic [P_W-1:0]         tree_q [0:2*NUM_TOPICS-1];
    logic [31:0]            rand_q;
    logic [P_W-1:0]         thr_q;
    logic [LOG2_TOPICS-1:0] node_q;
    logic [LOG2_TOPICS-1:0] build_q;
    logic [LVL_W-1:0]       lvl_q;

    // Node indices: leaves sit at N+a, which for power-of-two N is {1, a}.
    logic [LOG2_TOPICS:0] wr_idx;
    logic [LOG2_TOPICS:0] bld_idx;
    logic [LOG2_TOPICS:0] bld_lo_idx;
    logic [LOG2_TOPICS:0] bld_hi_idx;
    logic [LOG2_TOPICS:0] left_idx;
    logic [P_W-1:0]       left_p;
    logic                 go_right;
    logic [P_W-1:0]       mult_hi;

    assign wr_idx     = {1'b1, i_wr_addr};
    assign bld_idx    = {1'b0, build_q};
    assign bld_lo_idx = {build_q, 1'b0};
    assign bld_hi_idx = {build_q, 1'b1};
    assign left_idx   = {node_q, 1'b0};
    assign left_p     = tree_q[left_idx];
    // Right branch whenever the remaining threshold reaches the left subtree
    // weight; with a zero total this always holds, landing on topic N-1.
    assign go_right   = !(thr_q < left_p);
    // Threshold = floor(random/2^32 * total), always strictly below a nonzero total.
    assign mult_hi    = P_W'(((32 + P_W)'(rand_q) * (32 + P_W)'(tree_q[1])) >> 32);

`ifdef TREE_DBG_RD_EN
    // Debug peek at any node; address 0 is not a node and reads as zero.
    assign o_dbg_p = (i_dbg_addr == '0) ? '0 : tree_q[i_dbg_addr];
`endif

    // Control FSM, tree storage and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < 2 * NUM_TOPICS; i++) begin
                tree_q[i] <= '0;
            end
            rand_q    <= '0;
            thr_q     <= '0;
            node_q    <= '0;
            build_q   <= '0;
            lvl_q     <= '0;
            o_busy    <= 1'b0;
            o_valid   <= 1'b0;
            o_topic   <= '0;
            o_p_total <= '0;
            o_zero    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A write on the start edge lands before the build reads it.
                    if (i_wr_en) begin
                        tree_q[wr_idx] <= i_wr_p;
                    end
                    if (i_start) begin
                        rand_q  <= i_random;
                        build_q <= BUILD_FIRST;
                        o_busy  <= 1'b1;
                        state_q <= ST_BUILD;
                    end
                end
                ST_BUILD: begin
                    tree_q[bld_idx] <= tree_q[bld_lo_idx] + tree_q[bld_hi_idx];
                    if (build_q == BUILD_LAST) begin
                        state_q <= ST_MULT;
                    end else begin
                        build_q <= build_q - 1'b1;
                    end
                end
                ST_MULT: begin
                    thr_q     <= mult_hi;
                    o_p_total <= tree_q[1];
                    node_q    <= LOG2_TOPICS'(1);
                    lvl_q     <= '0;
                    state_q   <= ST_DESCEND;
                end
                ST_DESCEND: begin
                    if (go_right) begin
                        thr_q <= thr_q - left_p;
                    end
                    if (lvl_q == LVL_LAST) begin
                        // Final child index minus N is just its low bits.
                        o_topic <= 32'(LOG2_TOPICS'({node_q, go_right}));
                        o_zero  <= (o_p_total == '0);
                        o_valid <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        node_q <= LOG2_TOPICS'({node_q, go_right});
                        lvl_q  <= lvl_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    o_busy  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tree_descent_sampler.sv
// Directed scoreboard bench for tree_descent_sampler with 4 topics.
// Stimulus pushes expected results; a negedge monitor pops on each o_valid.
module tb_tree_descent_sampler;

    localparam int N   = 4;
    localparam int L   = 2;
    localparam int PW  = 32;
    localparam int LAT = N + L;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          wr_en   = 1'b0;
    logic [L-1:0]  wr_addr = '0;
    logic [PW-1:0] wr_p    = '0;
    logic          start   = 1'b0;
    logic [31:0]   rnd     = '0;
    logic          busy;
    logic          valid;
    logic [31:0]   topic;
    logic [PW-1:0] p_total;
    logic          zero;
`ifdef TREE_DBG_RD_EN
    logic [L:0]    dbg_addr = 3'd1;
    logic [PW-1:0] dbg_p;
`endif

    tree_descent_sampler #(
        .NUM_TOPICS (N),
        .LOG2_TOPICS(L),
        .P_W        (PW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_en  (wr_en),
        .i_wr_addr(wr_addr),
        .i_wr_p   (wr_p),
        .i_start  (start),
        .i_random (rnd),
`ifdef TREE_DBG_RD_EN
        .i_dbg_addr(dbg_addr),
        .o_dbg_p   (dbg_p),
`endif
        .o_busy   (busy),
        .o_valid  (valid),
        .o_topic  (topic),
        .o_p_total(p_total),
        .o_zero   (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   topic;
        logic [PW-1:0] total;
        logic          zero;
        int            start_cyc;
        string         name;
    } exp_t;

    exp_t sb[$];
    int   total_n = 0;
    int   bad_n   = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        total_n++;
        if (act !== req) begin
            bad_n++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Monitor: every o_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid) begin
            if (sb.size() == 0) begin
                total_n++;
                bad_n++;
                $display("FAIL unexpected_valid: got pulse with topic %0d, required none", topic);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_topic"}, 64'(topic), 64'(e.topic));
                chk({e.name, "_total"}, 64'(p_total), 64'(e.total));
                chk({e.name, "_zero"}, 64'(zero), 64'(e.zero));
                chk({e.name, "_latency"}, 64'(cyc - e.start_cyc), 64'(LAT));
                $display("txn %s: topic=%0d total=%0d zero=%0b latency=%0d",
                         e.name, topic, p_total, zero, cyc - e.start_cyc);
            end
        end
    end

    task automatic push_exp(string name, logic [31:0] et, logic [PW-1:0] ep, logic ez);
        exp_t e;
        e.topic     = et;
        e.total     = ep;
        e.zero      = ez;
        e.start_cyc = cyc;
        e.name      = name;
        sb.push_back(e);
    endtask

    task automatic wr(logic [L-1:0] a, logic [PW-1:0] v);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_p    = v;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic start_run(string name, logic [31:0] r, logic [31:0] et,
                             logic [PW-1:0] ep, logic ez);
        start = 1'b1;
        rnd   = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_exp(name, et, ep, ez);
    endtask

    task automatic wait_idle(string name);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            total_n++;
            bad_n++;
            $display("FAIL %s_timeout: got busy after %0d cycles, required idle", name, k);
        end
    endtask

    initial begin
        // Reset state.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_topic", 64'(topic), 64'd0);
        chk("rst_total", 64'(p_total), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Ranges over leaves {10,20,30,40}; runs are back-to-back.
        wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 40);
        start_run("half", 32'h8000_0000, 2, 100, 1'b0);
        wait_idle("half");
        start_run("rand0", 32'h0000_0000, 0, 100, 1'b0);
        wait_idle("rand0");
        start_run("randmax", 32'hFFFF_FFFF, 3, 100, 1'b0);
        wait_idle("randmax");

        // Start and write during DESCEND are both dropped.
        start_run("busy", 32'h8000_0000, 2, 100, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start   = 1'b1;
        rnd     = 32'hFFFF_FFFF;
        wr_en   = 1'b1;
        wr_addr = 0;
        wr_p    = 99;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        wait_idle("busy");
        repeat (3) @(negedge clk);
        chk("no_queued_start", 64'(busy), 64'd0);
        start_run("after_busy", 32'h0000_0000, 0, 100, 1'b0);
        wait_idle("after_busy");

        // Zero-weight leaves are never picked when the total is nonzero.
        wr(0, 0); wr(1, 0); wr(2, 5); wr(3, 0);
        start_run("sparse_a", 32'h1234_5678, 2, 5, 1'b0);
        wait_idle("sparse_a");
        start_run("sparse_b", 32'hFFFF_FFFF, 2, 5, 1'b0);
        wait_idle("sparse_b");

        // Write of leaf 3 on the start edge is part of that build.
        wr(0, 10); wr(1, 20); wr(2, 30);
        wr_en   = 1'b1;
        wr_addr = 3;
        wr_p    = 60;
        start   = 1'b1;
        rnd     = 32'h8000_0000;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        start = 1'b0;
        push_exp("collide", 3, 120, 1'b0);
        wait_idle("collide");
`ifdef TREE_DBG_RD_EN
        chk("dbg_root", 64'(dbg_p), 64'd120);
`endif

        // Reset mid-BUILD clears outputs at once and suppresses the result.
        start = 1'b1;
        rnd   = 32'h8000_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(valid), 64'd0);
        chk("midrst_topic", 64'(topic), 64'd0);
        chk("midrst_total", 64'(p_total), 64'd0);
        chk("midrst_zero", 64'(zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_idle", 64'(busy), 64'd0);

        // Tree was cleared by reset: all-zero weights pick topic N-1.
        start_run("zero_total", 32'h8000_0000, 3, 0, 1'b1);
        wait_idle("zero_total");

        repeat (3) @(negedge clk);
        chk("pending_results", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
